// File: rtl/pwm_tach_bank.sv
// Bank of NCH PWM generators sharing one period counter, plus NCH tachometer period meters.
// Define TACH_GLITCH_FILTER_EN to require 3 equal synchronised samples before a TACHIN level is accepted.
module pwm_tach_bank #(
    parameter int NCH = 2,
    parameter int CW  = 16,
    parameter int TW  = 16
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [2:0]        wr_ch,
    input  logic [CW-1:0]     wr_data,
    input  logic [NCH-1:0]    TACHIN,
    output logic [NCH-1:0]    PWM,
    output logic [NCH*TW-1:0] tach_period,
    output logic [NCH-1:0]    tach_valid,
    output logic [NCH-1:0]    tach_stb
);

    localparam logic [TW-1:0] TMAX = '1;

    logic [CW-1:0] period_sh, period_nx, p_act, cnt;
    logic [CW-1:0] duty_sh [NCH];
    logic [CW-1:0] duty_nx [NCH];
    logic [CW-1:0] d_act   [NCH];
    logic          load;

    // Next shadow values include this cycle's write, so a write on the wrap cycle goes live at that wrap.
    always_comb begin
        period_nx = period_sh;
        if (wr_en && !wr_sel)
            period_nx = wr_data;
        for (int i = 0; i < NCH; i++) begin
            duty_nx[i] = duty_sh[i];
            if (wr_en && wr_sel && (wr_ch == 3'(i)))
                duty_nx[i] = wr_data;
        end
        load = (cnt == p_act) || (p_act == '0);
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            period_sh <= '0;
            p_act     <= '0;
            cnt       <= '0;
            PWM       <= '0;
            for (int i = 0; i < NCH; i++) begin
                duty_sh[i] <= '0;
                d_act[i]   <= '0;
            end
        end else begin
            period_sh <= period_nx;
            for (int i = 0; i < NCH; i++)
                duty_sh[i] <= duty_nx[i];
            if (load) begin
                p_act <= period_nx;
                for (int i = 0; i < NCH; i++)
                    d_act[i] <= duty_nx[i];
            end
            if ((p_act == '0) || (cnt == p_act))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            for (int i = 0; i < NCH; i++)
                PWM[i] <= (p_act != '0) && (cnt < d_act[i]);
        end
    end

    logic [NCH-1:0] s1, s2, lvl_q, lvl_now, edge_det, armed;
    logic [TW-1:0]  tcnt [NCH];
    logic [TW-1:0]  tper [NCH];

`ifdef TACH_GLITCH_FILTER_EN
    logic [NCH-1:0] h1, h2;

    // Level flips only when the last three synchronised samples agree; otherwise it holds.
    always_comb lvl_now = (s2 & h1 & h2) | (lvl_q & (s2 | h1 | h2));

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            h1 <= '0;
            h2 <= '0;
        end else begin
            h1 <= s2;
            h2 <= h1;
        end
    end
`else
    always_comb lvl_now = s2;
`endif

    assign edge_det = lvl_now & ~lvl_q;

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            s1         <= '0;
            s2         <= '0;
            lvl_q      <= '0;
            armed      <= '0;
            tach_valid <= '0;
            tach_stb   <= '0;
            for (int i = 0; i < NCH; i++) begin
                tcnt[i] <= '0;
                tper[i] <= '0;
            end
        end else begin
            s1    <= TACHIN;
            s2    <= s1;
            lvl_q <= lvl_now;
            for (int i = 0; i < NCH; i++) begin
                tach_stb[i] <= 1'b0;
                if (edge_det[i]) begin
                    tcnt[i]  <= TW'(1);
                    armed[i] <= 1'b1;
                    if (armed[i]) begin
                        tper[i]       <= tcnt[i];
                        tach_valid[i] <= 1'b1;
                        tach_stb[i]   <= 1'b1;
                    end
                end else if (tcnt[i] != TMAX) begin
                    tcnt[i] <= tcnt[i] + TW'(1);
                    // Counter is about to saturate: report timeout and wait for a fresh arming edge.
                    if (tcnt[i] == TMAX - TW'(1)) begin
                        tper[i]       <= TMAX;
                        tach_valid[i] <= 1'b0;
                        armed[i]      <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_tper
        assign tach_period[g*TW +: TW] = tper[g];
    end

endmodule

// File: tb/tb_pwm_tach_bank.sv
// Directed bench for pwm_tach_bank (NCH=2, CW=16, TW=8); tach captures are scored against an expected queue.
module tb_pwm_tach_bank;

  localparam int NCH = 2;
  localparam int CW  = 16;
  localparam int TW  = 8;
`ifdef TACH_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic              SYSCLK = 1'b0;
  logic              NSYSRESET = 1'b1;
  logic              wr_en = 1'b0;
  logic              wr_sel = 1'b0;
  logic [2:0]        wr_ch = '0;
  logic [CW-1:0]     wr_data = '0;
  logic [NCH-1:0]    TACHIN = '0;
  logic [NCH-1:0]    PWM;
  logic [NCH*TW-1:0] tach_period;
  logic [NCH-1:0]    tach_valid;
  logic [NCH-1:0]    tach_stb;

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] exp_q[$];

  pwm_tach_bank #(.NCH(NCH), .CW(CW), .TW(TW)) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_ch(wr_ch), .wr_data(wr_data), .TACHIN(TACHIN), .PWM(PWM),
    .tach_period(tach_period), .tach_valid(tach_valid), .tach_stb(tach_stb)
  );

  // clock / watchdog
  always #5 SYSCLK = ~SYSCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    NSYSRESET = 1'b0;
    wr_en = 1'b0;
    TACHIN = '0;
    steps(2);
    NSYSRESET = 1'b1;
  endtask

  task automatic write(input logic sel, input logic [2:0] ch, input logic [CW-1:0] data);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_ch = ch;
    wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  // Leaves cnt=0 and period 9 active; the junk write targets a non-existent channel.
  task automatic setup(input logic [CW-1:0] d0, input logic [CW-1:0] d1);
    write(1'b1, 3'd0, d0);
    write(1'b1, 3'd1, d1);
    write(1'b1, 3'd3, 16'd5);
    write(1'b0, 3'd0, 16'd9);
  endtask

  task automatic capture_pwm(input int n, output logic [31:0] v0, output logic [31:0] v1);
    v0 = '0;
    v1 = '0;
    for (int k = 0; k < n; k++) begin
      step();
      v0[k] = PWM[0];
      v1[k] = PWM[1];
    end
  endtask

  task automatic drive_tach(input logic [NCH-1:0] mask, input int ch, input int high_len,
                            input int total, output int nstb, output int first_k,
                            output logic [NCH-1:0] stb_vec);
    nstb = 0;
    first_k = -1;
    stb_vec = '0;
    TACHIN = TACHIN | mask;
    for (int k = 0; k < total; k++) begin
      step();
      if (k + 1 == high_len) TACHIN = TACHIN & ~mask;
      if (tach_stb[ch]) begin
        if (nstb == 0) begin
          first_k = k + 1;
          stb_vec = tach_stb;
        end
        nstb++;
        if (exp_q.size() != 0)
          check("tach_period_sb", 32'(tach_period[ch*TW +: TW]), 32'(exp_q.pop_front()));
        else
          check("stb_unexpected", 32'(tach_stb[ch]), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] v0, v1;
    int n, fk;
    logic [NCH-1:0] sv;

    // reset values, checked while reset is held
    NSYSRESET = 1'b0;
    #2;
    check("rst_pwm", 32'(PWM), 32'd0);
    check("rst_tach_period", 32'(tach_period), 32'd0);
    check("rst_tach_valid", 32'(tach_valid), 32'd0);
    check("rst_tach_stb", 32'(tach_stb), 32'd0);
    do_reset();

    // period 0 keeps outputs low even with a nonzero duty
    write(1'b1, 3'd0, 16'd3);
    capture_pwm(5, v0, v1);
    check("p0_low", v0, 32'd0);

    // period 9, duty 3: 3 high, 7 low; out-of-range channel write ignored
    do_reset();
    setup(16'd3, 16'd0);
    capture_pwm(20, v0, v1);
    check("pwm_d3", v0, 32'h1C07);
    check("ch_oob_ignored", v1, 32'd0);

    // duty 0 then duty 10, each applied only at the next wrap; duty1 > period is constant high
    do_reset();
    setup(16'd3, 16'd12);
    write(1'b1, 3'd0, 16'd0);
    check("d0_wr_sample", 32'(PWM[0]), 32'd1);
    capture_pwm(9, v0, v1);
    check("d0_old_duty", v0, 32'h3);
    check("d1_above_p", v1, 32'h1FF);
    write(1'b1, 3'd0, 16'd10);
    check("d10_wr_sample", 32'(PWM[0]), 32'd0);
    capture_pwm(9, v0, v1);
    check("d0_zero_period", v0, 32'd0);
    capture_pwm(10, v0, v1);
    check("d10_full_period", v0, 32'h3FF);

    // duty write on the wrap cycle is live in the very next period
    do_reset();
    setup(16'd3, 16'd0);
    capture_pwm(9, v0, v1);
    check("wrap_pre", v0, 32'h7);
    write(1'b1, 3'd0, 16'd6);
    check("wrap_cycle", 32'(PWM[0]), 32'd0);
    capture_pwm(10, v0, v1);
    check("wrap_new_duty", v0, 32'h3F);

    // tach: arm, then capture 50
    do_reset();
    drive_tach(2'b10, 1, 5, 50, n, fk, sv);
    check("arm_no_stb", 32'(n), 32'd0);
    check("arm_not_valid", 32'(tach_valid), 32'd0);
    exp_q.push_back(8'd50);
    drive_tach(2'b10, 1, 5, 20, n, fk, sv);
    check("cap_stb_count", 32'(n), 32'd1);
    check("cap_latency", 32'(fk), 32'(LAT));
    check("cap_period1", 32'(tach_period[15:8]), 32'd50);
    check("cap_valid", 32'(tach_valid), 32'b10);
    check("ch0_untouched", 32'(tach_period[7:0]), 32'd0);

    // timeout, then re-arm without capture, then capture again
    steps(260);
    check("to_period", 32'(tach_period[15:8]), 32'hFF);
    check("to_valid", 32'(tach_valid[1]), 32'd0);
    drive_tach(2'b10, 1, 5, 30, n, fk, sv);
    check("rearm_no_stb", 32'(n), 32'd0);
    check("rearm_not_valid", 32'(tach_valid[1]), 32'd0);
    exp_q.push_back(8'd30);
    drive_tach(2'b10, 1, 5, 20, n, fk, sv);
    check("rearm_cap_count", 32'(n), 32'd1);
    check("rearm_valid", 32'(tach_valid[1]), 32'd1);

    // simultaneous edges on both channels capture in the same cycle
    do_reset();
    drive_tach(2'b11, 0, 5, 30, n, fk, sv);
    exp_q.push_back(8'd30);
    drive_tach(2'b11, 0, 5, 10, n, fk, sv);
    check("simul_stb", 32'(sv), 32'b11);
    check("simul_period", 32'(tach_period), 32'h1E1E);
    check("simul_valid", 32'(tach_valid), 32'b11);

    // short pulses on channel 0
    do_reset();
    drive_tach(2'b01, 0, 5, 20, n, fk, sv);
`ifdef TACH_GLITCH_FILTER_EN
    drive_tach(2'b01, 0, 2, 20, n, fk, sv);
    check("glitch_2_ignored", 32'(n), 32'd0);
    exp_q.push_back(8'd40);
    drive_tach(2'b01, 0, 3, 20, n, fk, sv);
    check("glitch_3_count", 32'(n), 32'd1);
    check("glitch_3_latency", 32'(fk), 32'd5);
`else
    exp_q.push_back(8'd20);
    drive_tach(2'b01, 0, 2, 20, n, fk, sv);
    check("pulse_2_count", 32'(n), 32'd1);
    exp_q.push_back(8'd20);
    drive_tach(2'b01, 0, 3, 20, n, fk, sv);
    check("pulse_3_count", 32'(n), 32'd1);
    check("pulse_3_latency", 32'(fk), 32'd3);
`endif

    // asynchronous reset mid-run clears everything immediately
    do_reset();
    setup(16'd3, 16'd0);
    drive_tach(2'b10, 1, 5, 20, n, fk, sv);
    exp_q.push_back(8'd20);
    drive_tach(2'b10, 1, 5, 11, n, fk, sv);
    check("pre_rst_pwm", 32'(PWM), 32'b01);
    check("pre_rst_valid", 32'(tach_valid), 32'b10);
    #2;
    NSYSRESET = 1'b0;
    #1;
    check("mid_rst_pwm", 32'(PWM), 32'd0);
    check("mid_rst_valid", 32'(tach_valid), 32'd0);
    check("mid_rst_period", 32'(tach_period), 32'd0);
    check("mid_rst_stb", 32'(tach_stb), 32'd0);
    steps(2);
    NSYSRESET = 1'b1;
    steps(2);

    // final report
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
